// File: rtl/edge_pkg.sv
// Shared pixel, angle and window types for the edge-detection datapath.
// The typedefs cover the default 8-bit magnitude; wider builds size their own vectors.
package edge_pkg;

  localparam int PIX_BITS = 8;

  typedef logic [PIX_BITS-1:0] pixel_t;
  typedef logic [1:0]          angle_t;
  typedef pixel_t [8:0]        window_t;

  localparam angle_t ANG_H    = 2'd0;
  localparam angle_t ANG_D45  = 2'd1;
  localparam angle_t ANG_V    = 2'd2;
  localparam angle_t ANG_D135 = 2'd3;

  localparam int CENTRE_IDX = 4;

endpackage

// File: rtl/nms_window_gen_if.sv
// Pixel-in / window-out bundle between a gradient source and the NMS window generator.
interface nms_window_gen_if #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int BITS  = 8
);
  logic                       in_valid;
  logic                       in_sof;
  logic [BITS-1:0]            in_mag;
  logic [1:0]                 in_angle;
  logic                       out_valid;
  logic [8:0][BITS-1:0]       out_mag;
  logic [1:0]                 out_angle;
  logic [$clog2(IMG_W)-1:0]   out_x;
  logic [$clog2(IMG_H)-1:0]   out_y;
  logic                       out_frame_done;

  modport master (
    output in_valid, in_sof, in_mag, in_angle,
    input  out_valid, out_mag, out_angle, out_x, out_y, out_frame_done
  );

  modport slave (
    input  in_valid, in_sof, in_mag, in_angle,
    output out_valid, out_mag, out_angle, out_x, out_y, out_frame_done
  );
endinterface

// File: rtl/nms_line_buffer.sv
// One image line of storage: combinational read of the old entry, write of the new
// entry on the same clock edge, so a column can be shifted down in a single cycle.
module nms_line_buffer #(
  parameter int DEPTH = 320,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/nms_window_gen.sv
// Builds the 3x3 magnitude window plus centre angle for non-maximum suppression
// from a raster stream, emitting one window per interior centre pixel.
module nms_window_gen
  import edge_pkg::*;
#(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int BITS  = 8
) (
  input  logic            clk,
  input  logic            rst,
  nms_window_gen_if.slave bus
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  logic [XW-1:0]        x_cnt, px;
  logic [YW-1:0]        y_cnt, py;
  logic                 last_col, last_row, interior;
  logic [BITS+1:0]      lb0_rd;
  logic [BITS-1:0]      lb1_rd;
  logic [8:0][BITS-1:0] win_p1;
  angle_t               ang_p0, ang_p1;
  logic [XW-1:0]        cx_p1;
  logic [YW-1:0]        cy_p1;
  logic                 vld_p1, done_p1;

  // A start-of-frame pixel is always (0,0), whatever the counters say.
  always_comb begin
    px       = bus.in_sof ? '0 : x_cnt;
    py       = bus.in_sof ? '0 : y_cnt;
    last_col = (px == XW'(IMG_W - 1));
    last_row = (py == YW'(IMG_H - 1));
    interior = (px >= XW'(2)) && (py >= YW'(2));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (bus.in_valid) begin
      if (last_col) begin
        x_cnt <= '0;
        y_cnt <= last_row ? '0 : py + YW'(1);
      end else begin
        x_cnt <= px + XW'(1);
        y_cnt <= py;
      end
    end
  end

  nms_line_buffer #(.DEPTH(IMG_W), .WIDTH(BITS + 2)) lb0 (
    .clk   (clk),
    .we    (bus.in_valid),
    .addr  (px),
    .wdata ({bus.in_mag, bus.in_angle}),
    .rdata (lb0_rd)
  );

  nms_line_buffer #(.DEPTH(IMG_W), .WIDTH(BITS)) lb1 (
    .clk   (clk),
    .we    (bus.in_valid),
    .addr  (px),
    .wdata (lb0_rd[BITS+1:2]),
    .rdata (lb1_rd)
  );

  // p0 -> p1: shift window left one column, new column enters on the right
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_p1 <= '0;
      ang_p0 <= ANG_H;
      ang_p1 <= ANG_H;
      cx_p1  <= '0;
      cy_p1  <= '0;
    end else if (bus.in_valid) begin
      for (int r = 0; r < 3; r++) begin
        win_p1[r*3]   <= win_p1[r*3+1];
        win_p1[r*3+1] <= win_p1[r*3+2];
      end
      win_p1[2] <= lb1_rd;
      win_p1[5] <= lb0_rd[BITS+1:2];
      win_p1[8] <= bus.in_mag;
      ang_p0    <= lb0_rd[1:0];
      ang_p1    <= ang_p0;
      cx_p1     <= px - XW'(1);
      cy_p1     <= py - YW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
    end else begin
      vld_p1  <= bus.in_valid && interior;
      done_p1 <= bus.in_valid && last_col && last_row;
    end
  end

  assign bus.out_valid      = vld_p1;
  assign bus.out_mag        = win_p1;
  assign bus.out_angle      = ang_p1;
  assign bus.out_x          = cx_p1;
  assign bus.out_y          = cy_p1;
  assign bus.out_frame_done = done_p1;

endmodule

// File: doc/nms_window_gen.md
Name: nms_window_gen

Overview:
Streaming producer of the 3x3 magnitude window and centre-pixel angle consumed by the non-maximum-suppression stage. It accepts gradient magnitude and quantised angle one pixel per cycle in raster order. It buffers two image lines and emits a registered window for every interior centre pixel, together with the centre coordinates and a frame-done pulse.

Parameters:
IMG_W, 320, image width in pixels (at least 3)
IMG_H, 240, image height in lines (at least 3)
BITS, 8, magnitude width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  pixel accepted this cycle; no backpressure
in_sof  in  1  qualifies in_valid; this pixel is (x=0, y=0)
in_mag  in  BITS  gradient magnitude
in_angle  in  2  quantised direction: 0 horizontal, 1 diagonal 45, 2 vertical, 3 diagonal 135
out_valid  out  1  window valid, one-cycle pulse per accepted interior pixel
out_mag  out  [8:0][BITS-1:0]  window, index = row*3+col; row 0 top (oldest), col 0 left; [4] = centre
out_angle  out  2  angle of the centre pixel
out_x  out  $clog2(IMG_W)  centre column
out_y  out  $clog2(IMG_H)  centre row
out_frame_done  out  1  one-cycle pulse after the last pixel of the frame is accepted

Behaviour:
- Reset (async, rst=1): x/y counters, window registers, angle pipe and all outputs go to 0. Line-buffer RAM is not cleared.
- Counters: x/y give the position of the incoming pixel.
  - On an accepted pixel: x increments; at IMG_W-1, x wraps to 0 and y increments.
  - At (IMG_W-1, IMG_H-1): both wrap to 0.
  - in_sof with in_valid forces the accepted pixel to (0,0); the counters then advance from there. in_sof without in_valid is ignored.
- Line buffers: lb0 holds row y-1 and lb1 holds row y-2, each IMG_W entries.
  - lb0 entries are BITS+2 wide (magnitude + angle); lb1 entries are BITS wide.
  - For an accepted pixel at column x, in one cycle: read lb0[x] and lb1[x], write lb1[x] <= lb0[x].mag, write lb0[x] <= {in_mag, in_angle}. Read-before-write at the same address.
- Window shift on an accepted pixel:
  - col0 <= col1, col1 <= col2.
  - col2 <= {top = lb1[x], mid = lb0[x].mag, bottom = in_mag}.
  - Angle pipe: a2 <= lb0[x].angle, out_angle <= a2.
  - The window centre is then (x-1, y-1).
- out_valid <= in_valid && x >= 2 && y >= 2, registered. out_mag, out_angle, out_x and out_y update in the same edge.
  - Latency: 1 clk from accepting pixel (x,y) to the window centred at (x-1, y-1).
- in_valid=0: counters, buffers and window hold; out_valid is 0 the next cycle.
  - Gaps of any length are allowed mid-line and between lines.
- Border pixels (row 0, row IMG_H-1, col 0, col IMG_W-1) never appear as a centre.
  - At each row start the window contains the previous row's tail; x<2 gating hides it.
  - Stale line-buffer data is hidden by y<2 gating.
- Valid windows per frame: (IMG_W-2)*(IMG_H-2).
- out_frame_done <= accepted pixel at (IMG_W-1, IMG_H-1). It coincides with the last out_valid of the frame.
- Reset mid-frame: the next accepted pixel is (0,0); no window straddles the reset.
- in_sof mid-frame: the partial frame is abandoned, with no out_frame_done for it. Outputs resume only after two new lines plus two pixels.

Decomposition:
- Package edge_pkg:
  - typedef pixel_t [BITS-1:0]
  - typedef angle_t [1:0]
  - typedef window_t [8:0] pixel_t
  - constants ANG_H=0, ANG_D45=1, ANG_V=2, ANG_D135=3
  - constant CENTRE_IDX=4
- Sub-module nms_line_buffer: a single-port IMG_W x WIDTH array with same-cycle read-old/write-new. It is instantiated twice, lb0 with WIDTH=BITS+2 and lb1 with WIDTH=BITS.

Test Plan:
- IMG_W=5, IMG_H=4; pixel mag=y*16+x, angle=x%4; continuous in_valid with in_sof on the first pixel.
  - First out_valid comes 1 clk after pixel (2,2), with out_x=1, out_y=1, out_angle=1.
  - out_mag[0..8] = 00,01,02,10,11,12,20,21,22 (hex).
  - 6 windows total; last window centre is (3,2) = {12,13,14,22,23,24,32,33,34}, with out_frame_done high.
- Same stream with in_valid dropped for 3 cycles at random points -> identical window sequence and coordinates; out_valid low during gaps.
- Two back-to-back frames, second frame mag=0xFF-(y*16+x) -> second frame's first window contains only frame-2 values. No window is emitted for y<2 of frame 2.
- rst pulsed asynchronously (mid-cycle) at pixel (3,2) -> all outputs 0 immediately. Restart with in_sof gives the first window at centre (1,1) with correct values.
- in_sof asserted at pixel (1,2) of frame 1 -> no out_frame_done for frame 1. The new frame behaves like the first scenario.
- Row-wrap check, IMG_W=3, IMG_H=3 -> exactly 1 window, centre (1,1), out_frame_done in the same cycle.
